i2c_diag_frame_rx: RTL



---
 rtl/i2c_diag_pkg.sv | 10 +
 rtl/i2c_diag_frame_rx_filter.sv | 39 +++
 rtl/i2c_diag_frame_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/i2c_diag_pkg.sv
// i2c_diag_pkg: shared state, error codes and frame constants for the diagnostic I2C link
package i2c_diag_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    localparam int FRAME_BYTES = 3;
    localparam logic [6:0] DEF_I2C_ADDR = 7'h5D;
endpackage

// File: rtl/i2c_diag_frame_rx_filter.sv
// i2c_line_filter: two-flop synchroniser plus run-length debounce with edge pulses
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic cam1_pclk,
    input  logic cam_resetn,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    // level flips only after FILT_LEN consecutive synchronised samples disagree with it
    always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
        if (!cam_resetn) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                level <= sync[1];
                rise  <= sync[1];
                fall  <= !sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_diag_frame_rx.sv
// i2c_diag_frame_rx: I2C write target that collects page/value diagnostic frames
module i2c_diag_frame_rx
    import i2c_diag_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR     = DEF_I2C_ADDR,
    parameter int         FILT_LEN     = 4,
    parameter int         TIMEOUT_CLKS = 270000
) (
    input  logic        cam1_pclk,
    input  logic        cam_resetn,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        frame_valid,
    output logic [7:0]  frame_page,
    output logic [15:0] frame_value,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [1:0]  last_err
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    state_t        state;
    logic          scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
    logic          start_ev, stop_ev, timeout, match, slot, overrun;
    logic [2:0]    bit_cnt, nbytes;
    logic [7:0]    shreg, pg, vh, vl, nxt;
    logic [TW-1:0] to_cnt;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .cam1_pclk(cam1_pclk), .cam_resetn(cam_resetn), .line_in(scl_in),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .cam1_pclk(cam1_pclk), .cam_resetn(cam_resetn), .line_in(sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_ev = sda_fall && scl_lvl;
    assign stop_ev  = sda_rise && scl_lvl;
    assign timeout  = to_cnt == TW'(TIMEOUT_CLKS);
    assign nxt      = {shreg[6:0], sda_lvl};

    // stall watchdog: counts only while engaged on the bus, any SCL edge restarts it
    always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
        if (!cam_resetn) to_cnt <= '0;
        else to_cnt <= (state == IDLE || state == IGNORE || scl_rise || scl_fall) ? '0 : to_cnt + 1'b1;
    end

    // protocol FSM; bus conditions take priority over bit handling, STOP over timeout
    always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
        if (!cam_resetn) begin
            state       <= IDLE;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            slot        <= 1'b0;
            match       <= 1'b0;
            overrun     <= 1'b0;
            bit_cnt     <= '0;
            nbytes      <= '0;
            shreg       <= '0;
            pg          <= '0;
            vh          <= '0;
            vl          <= '0;
            frame_valid <= 1'b0;
            frame_page  <= '0;
            frame_value <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            last_err    <= ERR_NONE;
        end else begin
            frame_valid <= 1'b0;
            if (state != IDLE && stop_ev) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                slot   <= 1'b0;
                if (busy && overrun) begin
                    err_cnt  <= err_cnt + 1'b1;
                    last_err <= ERR_OVERRUN;
                end else if (busy && nbytes == 3'(FRAME_BYTES)) begin
                    frame_valid <= 1'b1;
                    frame_page  <= pg;
                    frame_value <= {vh, vl};
                    frame_cnt   <= frame_cnt + 1'b1;
                end else if (busy && nbytes != 3'd0) begin
                    err_cnt  <= err_cnt + 1'b1;
                    last_err <= ERR_SHORT;
                end
            end else if (start_ev) begin
                if (busy && nbytes != 3'd0 && nbytes < 3'(FRAME_BYTES)) begin
                    err_cnt  <= err_cnt + 1'b1;
                    last_err <= ERR_SHORT;
                end
                state   <= ADDR;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                slot    <= 1'b0;
                overrun <= 1'b0;
                bit_cnt <= '0;
                nbytes  <= '0;
            end else if (timeout) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                slot     <= 1'b0;
                err_cnt  <= err_cnt + 1'b1;
                last_err <= ERR_TIMEOUT;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ADDR_ACK;
                            match <= nxt[7:1] == I2C_ADDR && !nxt[0];
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (slot) begin
                            slot    <= 1'b0;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else if (match) begin
                            slot   <= 1'b1;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    DATA: if (scl_rise) begin
                        shreg   <= nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state  <= DATA_ACK;
                            nbytes <= (nbytes == 3'd4) ? nbytes : nbytes + 1'b1;
                            if (nbytes == 3'd0) pg <= nxt;
                            if (nbytes == 3'd1) vh <= nxt;
                            if (nbytes == 3'd2) vl <= nxt;
                        end
                    end
                    DATA_ACK: if (scl_fall) begin
                        if (slot) begin
                            slot    <= 1'b0;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            slot    <= 1'b1;
                            sda_oe  <= nbytes <= 3'(FRAME_BYTES);
                            overrun <= overrun || nbytes > 3'(FRAME_BYTES);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
